// File: rtl/comparator_seq.sv
// Sequential chunked comparator for RISC-V branch conditions, one CHUNK_WIDTH slice per cycle.
// Define CMP_EARLY_EXIT_EN to finish on the first unequal chunk instead of scanning every chunk.
module comparator_seq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  f,
    output logic                  eq,
    output logic                  lt
);

    localparam int unsigned NChunk = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;

`ifdef CMP_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [2:0]            mode_q, mode_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  found_q, found_d;
    logic                  lt_acc_q, lt_acc_d;
    logic                  f_q, f_d;
    logic                  eq_q, eq_d;
    logic                  lt_q, lt_d;

    logic [CHUNK_WIDTH-1:0] chunk_a, chunk_b;
    logic                   chunk_ne, chunk_lt;
    logic                   eq_now, lt_now, finish;

    function automatic logic predicate(input logic [2:0] m, input logic e, input logic l);
        case (m)
            3'b000:  return e;
            3'b001:  return !e;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return l;
            3'b111:  return !l;
            default: return 1'b0;
        endcase
    endfunction

    // Select the current chunk; signed modes flip the sign bit of the MSB chunk so an
    // unsigned compare of that chunk orders two's-complement values correctly.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < int'(NChunk); i++) begin
            if (idx_q == IdxW'(i)) begin
                chunk_a = a_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
                chunk_b = b_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
        if (mode_q[2:1] == 2'b10 && idx_q == IdxW'(NChunk - 1)) begin
            chunk_a[CHUNK_WIDTH-1] = !chunk_a[CHUNK_WIDTH-1];
            chunk_b[CHUNK_WIDTH-1] = !chunk_b[CHUNK_WIDTH-1];
        end
        chunk_ne = (chunk_a != chunk_b);
        chunk_lt = (chunk_a < chunk_b);
    end

    // Only the first unequal chunk decides the ordering; later chunks are ignored.
    always_comb begin
        eq_now = !(found_q || chunk_ne);
        lt_now = found_q ? lt_acc_q : (chunk_ne && chunk_lt);
        finish = (idx_q == '0) || (EarlyExit && chunk_ne);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        found_d  = found_q;
        lt_acc_d = lt_acc_q;
        f_d      = f_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    mode_d   = mode;
                    idx_d    = IdxW'(NChunk - 1);
                    found_d  = 1'b0;
                    lt_acc_d = 1'b0;
                    state_d  = StCmp;
                end else begin
                    state_d = StIdle;
                end
            end
            StCmp: begin
                found_d  = found_q || chunk_ne;
                lt_acc_d = lt_now;
                if (finish) begin
                    idx_d   = '0;
                    eq_d    = eq_now;
                    lt_d    = lt_now;
                    f_d     = predicate(mode_q, eq_now, lt_now);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
            lt_acc_q <= 1'b0;
            f_q      <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            lt_acc_q <= lt_acc_d;
            f_q      <= f_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign busy = (state_q == StCmp);
    assign done = (state_q == StDone);
    assign f    = f_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Self-checking bench for comparator_seq: directed vectors plus randomized compares
// against an arithmetic reference model; honours CMP_EARLY_EXIT_EN for latency.
module tb_comparator_seq;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NC = DW / CW;
    localparam int MaxWait = 20;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [DW-1:0] a, b;
    logic [2:0]    mode;
    logic          busy, done, f, eq, lt;

    int checks   = 0;
    int failures = 0;

    comparator_seq #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .mode(mode),
        .busy(busy), .done(done), .f(f), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    // Returns {f, eq, lt} from the mode rules using native signed/unsigned compares.
    function automatic logic [2:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                         input logic [2:0] m);
        logic e, l, p;
        e = (x == y);
        l = (m[2:1] == 2'b10) ? ($signed(x) < $signed(y)) : (x < y);
        case (m)
            3'b000: p = e;
            3'b001: p = !e;
            3'b100, 3'b110: p = l;
            3'b101, 3'b111: p = !l;
            default: p = 1'b0;
        endcase
        return {p, e, l};
    endfunction

    function automatic int model_lat(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int k;
        k = 0;
`ifdef CMP_EARLY_EXIT_EN
        for (int i = NC - 1; i >= 0; i--) begin
            k++;
            if (x[i*CW +: CW] != y[i*CW +: CW]) break;
        end
`else
        k = NC;
`endif
        return k + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start for one cycle, scramble inputs afterwards, and wait for done.
    task automatic run_cmp(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [2:0] m,
                           output int lat, output logic [2:0] res, output logic to);
        start = 1'b1;
        a     = x;
        b     = y;
        mode  = m;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        mode  = 3'($urandom_range(0, 7));
        lat   = 1;
        to    = 1'b0;
        while (!done && lat < MaxWait) begin
            tick();
            lat++;
        end
        to  = !done;
        res = {f, eq, lt};
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = '1;
        b     = '0;
        mode  = 3'b111;
        tick();
        tick();
        checks++;
        if ({busy, done, f, eq, lt} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000", {busy, done, f, eq, lt});
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_vectors();
        logic [DW-1:0] va [5] = '{32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                  32'h00000000};
        logic [DW-1:0] vb [5] = '{32'h12345678, 32'h00000001, 32'h00000001, 32'h00000000,
                                  32'h80000000};
        logic [2:0]    vm [5] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b101};
        int lat;
        logic [2:0] res, exp;
        logic to;
        for (int i = 0; i < 5; i++) begin
            exp = model(va[i], vb[i], vm[i]);
            run_cmp(va[i], vb[i], vm[i], lat, res, to);
            checks++;
            if (to || lat != model_lat(va[i], vb[i])) begin
                failures++;
                $display("FAIL vec%0d_latency got=%0d want=%0d timeout=%b",
                         i, lat, model_lat(va[i], vb[i]), to);
            end
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL vec%0d_result f_eq_lt got=%b want=%b", i, res, exp);
            end
            tick();
            tick();
            checks++;
            if ({done, f, eq, lt} !== {1'b0, exp}) begin
                failures++;
                $display("FAIL vec%0d_hold done_f_eq_lt got=%b want=0%b", i,
                         {done, f, eq, lt}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] x, y;
        logic [2:0] m, res, exp;
        int lat;
        logic to;
        for (int n = 0; n < 60; n++) begin
            x = $urandom;
            y = x;
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 3) == 0) y[c*CW +: CW] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) y[DW-1] = !y[DW-1];
            m = 3'($urandom_range(0, 7));
            exp = model(x, y, m);
            run_cmp(x, y, m, lat, res, to);
            checks++;
            if (to || lat != model_lat(x, y) || res !== exp) begin
                failures++;
                $display("FAIL rand%0d a=%h b=%h mode=%b got lat=%0d res=%b want lat=%0d res=%b",
                         n, x, y, m, lat, res, model_lat(x, y), exp);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] x, y;
        logic [2:0] m, res, exp;
        int lat;
        logic to;
        for (int n = 0; n < 8; n++) begin
            x = $urandom;
            y = (n % 2 == 0) ? x : 32'($urandom);
            m = 3'($urandom_range(0, 7));
            exp = model(x, y, m);
            run_cmp(x, y, m, lat, res, to);
            checks++;
            if (to || lat != model_lat(x, y) || res !== exp) begin
                failures++;
                $display("FAIL b2b%0d got lat=%0d res=%b want lat=%0d res=%b",
                         n, lat, res, model_lat(x, y), exp);
            end
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int pulses, first;
        logic [2:0] res;
        pulses = 0;
        first  = -1;
        res    = 3'bxxx;
        start = 1'b1; a = 32'd1; b = 32'd2; mode = 3'b000;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_asserted busy=%b want=1", busy);
        end
        tick();
        start = 1'b1; a = 32'd5; b = 32'd5;
        tick();
        start = 1'b0;
        for (int c = 3; c < 14; c++) begin
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    res   = {f, eq, lt};
                end
            end
            tick();
        end
        checks++;
        if (pulses != 1 || first != NC + 1) begin
            failures++;
            $display("FAIL busy_ignore pulses=%0d at=%0d want pulses=1 at=%0d",
                     pulses, first, NC + 1);
        end
        checks++;
        if (res !== model(32'd1, 32'd2, 3'b000)) begin
            failures++;
            $display("FAIL busy_ignore_result got=%b want=%b", res, model(32'd1, 32'd2, 3'b000));
        end
    endtask

    task automatic test_reset_abort();
        int lat, pulses;
        logic [2:0] res;
        logic to;
        // Leave nonzero results behind so the reset clearing is observable.
        run_cmp(32'h55, 32'h55, 3'b000, lat, res, to);
        tick();
        start = 1'b1; a = 32'h7; b = 32'h7; mode = 3'b000;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, f, eq, lt} !== 5'b0) begin
            failures++;
            $display("FAIL abort_outputs got=%b want=00000", {busy, done, f, eq, lt});
        end
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_no_done pulses=%0d want=0", pulses);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_over_start busy=%b want=0", busy);
        end
        run_cmp(32'h9, 32'h9, 3'b011, lat, res, to);
        checks++;
        if (to || res !== model(32'h9, 32'h9, 3'b011)) begin
            failures++;
            $display("FAIL mode011 got=%b want=%b timeout=%b", res,
                     model(32'h9, 32'h9, 3'b011), to);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = '0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
